// File: rtl/aurora_tx_gearbox_66to20.sv
`default_nettype none
// ============================================================================
// aurora_tx_gearbox_66to20 - per-lane 66b->20b Aurora TX gearbox with idle fill;
// define AURORA_TX_SCRAMBLER_EN to scramble payloads (x^58+x^39+1).   Rev 1.0
// ============================================================================
module aurora_tx_gearbox_66to20 #(
  parameter logic [1:0]  IDLE_HDR     = 2'b10,
  parameter logic [63:0] IDLE_PAYLOAD = 64'h7800_0000_0000_0000
) (
  input  logic        SER_WORD_CLK,
  input  logic        RST_B,
  input  logic        LANE_EN,
  input  logic [1:0]  BLK_HDR,
  input  logic [63:0] BLK_DATA,
  input  logic        BLK_VALID,
  output logic        BLK_READY,
  output logic [19:0] SER_WORD,
  output logic        IDLE_INS
);

  localparam logic [6:0] WORD_BITS = 7'd20;
  localparam logic [6:0] LOAD_GAIN = 7'd46;

  logic [64:0] buf_q, buf_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [19:0] word_q, word_d;
  logic        idle_q, idle_d;
  logic        need_load;
  logic [1:0]  hdr_sel;
  logic [63:0] pay_sel;
  logic [63:0] pay_tx;
  logic [84:0] cat;

  assign need_load = (cnt_q < WORD_BITS);
  // Reset term keeps READY low the instant RST_B falls, without waiting for an edge.
  assign BLK_READY = LANE_EN & RST_B & need_load;
  assign hdr_sel   = BLK_VALID ? BLK_HDR  : IDLE_HDR;
  assign pay_sel   = BLK_VALID ? BLK_DATA : IDLE_PAYLOAD;

`ifdef AURORA_TX_SCRAMBLER_EN
  logic [57:0] scr_q, scr_d;

  always_comb begin
    scr_d  = scr_q;
    pay_tx = '0;
    for (int i = 63; i >= 0; i--) begin
      pay_tx[i] = pay_sel[i] ^ scr_d[38] ^ scr_d[57];
      scr_d     = {scr_d[56:0], pay_tx[i]};
    end
  end

  always_ff @(posedge SER_WORD_CLK or negedge RST_B) begin
    if (!RST_B) begin
      scr_q <= '1;
    end else if (!LANE_EN) begin
      scr_q <= '1;
    end else if (need_load) begin
      scr_q <= scr_d;
    end
  end
`else
  assign pay_tx = pay_sel;
`endif

  // Residue stays left-aligned with zeros below it, so OR-merging the shifted block is exact.
  always_comb begin
    cat    = {buf_q, 20'b0} | ({hdr_sel, pay_tx, 19'b0} >> cnt_q);
    buf_d  = buf_q;
    cnt_d  = cnt_q;
    word_d = word_q;
    idle_d = 1'b0;
    if (!LANE_EN) begin
      buf_d  = '0;
      cnt_d  = '0;
      word_d = '0;
    end else if (!need_load) begin
      word_d = buf_q[64:45];
      buf_d  = {buf_q[44:0], 20'b0};
      cnt_d  = cnt_q - WORD_BITS;
    end else begin
      word_d = cat[84:65];
      buf_d  = cat[64:0];
      cnt_d  = cnt_q + LOAD_GAIN;
      idle_d = ~BLK_VALID;
    end
  end

  always_ff @(posedge SER_WORD_CLK or negedge RST_B) begin
    if (!RST_B) begin
      buf_q  <= '0;
      cnt_q  <= '0;
      word_q <= '0;
      idle_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
      word_q <= word_d;
      idle_q <= idle_d;
    end
  end

  assign SER_WORD = word_q;
  assign IDLE_INS = idle_q;

endmodule
`default_nettype wire

// File: tb/tb_aurora_tx_gearbox_66to20.sv
`default_nettype none
// Testbench for aurora_tx_gearbox_66to20: bit-queue reference model, randomized and directed scenarios.
module tb_aurora_tx_gearbox_66to20;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        lane_en;
  logic [1:0]  blk_hdr;
  logic [63:0] blk_data;
  logic        blk_valid;
  logic        blk_ready;
  logic [19:0] ser_word;
  logic        idle_ins;

  int n_checks = 0;
  int n_fail   = 0;

  bit          mq[$];
  logic [19:0] ref_idle_words[0:39];
`ifdef AURORA_TX_SCRAMBLER_EN
  logic [57:0] mscr;
`endif

  always #5 clk = ~clk;

  aurora_tx_gearbox_66to20 dut (
    .SER_WORD_CLK (clk),
    .RST_B        (rst_b),
    .LANE_EN      (lane_en),
    .BLK_HDR      (blk_hdr),
    .BLK_DATA     (blk_data),
    .BLK_VALID    (blk_valid),
    .BLK_READY    (blk_ready),
    .SER_WORD     (ser_word),
    .IDLE_INS     (idle_ins)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic model_reset();
    mq.delete();
`ifdef AURORA_TX_SCRAMBLER_EN
    mscr = '1;
`endif
  endtask

  // Reference: the lane is a FIFO of bits; top it up with a whole block when fewer than 20 remain.
  task automatic model_step(input logic en, input logic vld, input logic [1:0] hdr,
                            input logic [63:0] data, output logic e_rdy,
                            output logic [19:0] e_word, output logic e_idle);
    logic [65:0] blk;
    e_rdy  = en && (mq.size() < 20);
    e_word = '0;
    e_idle = 1'b0;
    if (!en) begin
      model_reset();
      return;
    end
    if (mq.size() < 20) begin
      blk    = vld ? {hdr, data} : {2'b10, 64'h7800_0000_0000_0000};
      e_idle = !vld;
`ifdef AURORA_TX_SCRAMBLER_EN
      for (int i = 63; i >= 0; i--) begin
        bit s;
        s      = blk[i] ^ mscr[38] ^ mscr[57];
        mscr   = {mscr[56:0], s};
        blk[i] = s;
      end
`endif
      for (int i = 65; i >= 0; i--) mq.push_back(blk[i]);
    end
    for (int i = 0; i < 20; i++) e_word = {e_word[18:0], mq.pop_front()};
  endtask

  task automatic step(input logic en, input logic vld, input logic [1:0] hdr, input logic [63:0] data,
                      output logic o_rdy, output logic e_rdy,
                      output logic [19:0] o_word, output logic [19:0] e_word,
                      output logic o_idle, output logic e_idle);
    lane_en   = en;
    blk_valid = vld;
    blk_hdr   = hdr;
    blk_data  = data;
    #1;
    o_rdy = blk_ready;
    model_step(en, vld, hdr, data, e_rdy, e_word, e_idle);
    @(posedge clk);
    #1;
    o_word = ser_word;
    o_idle = idle_ins;
  endtask

  task automatic do_reset();
    rst_b     = 1'b0;
    lane_en   = 1'b1;
    blk_valid = 1'b0;
    blk_hdr   = 2'b01;
    blk_data  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_b     = 1'b0;
    lane_en   = 1'b1;
    blk_valid = 1'b1;
    blk_hdr   = 2'b01;
    blk_data  = 64'h1234;
    @(posedge clk);
    #2;
    n_checks++; if (ser_word !== 20'h0) begin n_fail++; $display("FAIL reset_word: got %h expected 00000", ser_word); end
    n_checks++; if (blk_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", blk_ready); end
    n_checks++; if (idle_ins !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got %b expected 0", idle_ins); end
    rst_b = 1'b1;
    model_reset();
    #1;
    n_checks++; if (blk_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b expected 1", blk_ready); end
    @(posedge clk);
    #1;
    rst_b = 1'b0;
  endtask

  task automatic test_idle_stream();
    logic or_, er, oi, ei;
    logic [19:0] ow, ew;
    logic [19:0] obs[0:39];
    int idles;
    do_reset();
    idles = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b0, 2'b01, 64'h0, or_, er, ow, ew, oi, ei);
      obs[k] = ow;
      ref_idle_words[k] = ew;
      if (k < 33 && oi === 1'b1) idles++;
      n_checks++; if (or_ !== er) begin n_fail++; $display("FAIL idle_ready[%0d]: got %b expected %b", k, or_, er); end
      n_checks++; if (ow !== ew) begin n_fail++; $display("FAIL idle_word[%0d]: got %h expected %h", k, ow, ew); end
      n_checks++; if (oi !== ei) begin n_fail++; $display("FAIL idle_pulse[%0d]: got %b expected %b", k, oi, ei); end
    end
    n_checks++; if (idles != 10) begin n_fail++; $display("FAIL idle_count: got %0d expected 10", idles); end
`ifndef AURORA_TX_SCRAMBLER_EN
    n_checks++; if (obs[0] !== 20'h9E000) begin n_fail++; $display("FAIL idle_first_word: got %h expected 9e000", obs[0]); end
    for (int k = 0; k < 7; k++) begin
      n_checks++;
      if (obs[k] !== obs[k+33]) begin n_fail++; $display("FAIL idle_period[%0d]: got %h expected %h", k, obs[k+33], obs[k]); end
    end
`endif
  endtask

  task automatic test_stream();
    logic or_, er, oi, ei;
    logic [19:0] ow, ew;
    logic [63:0] d;
    logic [65:0] sent[$];
    logic [65:0] got, exp;
    bit rx[$];
    int rdys;
    do_reset();
    d    = 64'hA5A5_0000_0000_0000 + 64'($urandom_range(0, 1000));
    rdys = 0;
    for (int k = 0; k < 66; k++) begin
      step(1'b1, 1'b1, 2'b01, d, or_, er, ow, ew, oi, ei);
      if (or_ === 1'b1) begin
        sent.push_back({2'b01, d});
        d = d + 64'd1;
        if (k < 33) rdys++;
      end
      for (int b = 19; b >= 0; b--) rx.push_back(ow[b]);
      n_checks++; if (or_ !== er) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b expected %b", k, or_, er); end
      n_checks++; if (ow !== ew) begin n_fail++; $display("FAIL stream_word[%0d]: got %h expected %h", k, ow, ew); end
      n_checks++; if (oi !== 1'b0) begin n_fail++; $display("FAIL stream_idle[%0d]: got %b expected 0", k, oi); end
    end
    n_checks++; if (rdys != 10) begin n_fail++; $display("FAIL stream_ready_count: got %0d expected 10", rdys); end
`ifndef AURORA_TX_SCRAMBLER_EN
    n_checks++; if (sent.size() < 19) begin n_fail++; $display("FAIL stream_accepted: got %0d expected >= 19", sent.size()); end
    while (rx.size() >= 66 && sent.size() > 0) begin
      for (int b = 65; b >= 0; b--) got[b] = rx.pop_front();
      exp = sent.pop_front();
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL stream_deser: got %h expected %h", got, exp); end
    end
`endif
  endtask

  task automatic test_boundary();
    logic or_, er, oi, ei;
    logic [19:0] ow, ew;
    do_reset();
    for (int k = 0; k < 13; k++)
      step(1'b1, 1'b1, 2'b01, {$urandom, $urandom}, or_, er, ow, ew, oi, ei);
    step(1'b1, 1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, or_, er, ow, ew, oi, ei);
    n_checks++; if (or_ !== 1'b1) begin n_fail++; $display("FAIL cnt4_ready: got %b expected 1", or_); end
    n_checks++; if (ow !== ew) begin n_fail++; $display("FAIL cnt4_word: got %h expected %h", ow, ew); end
`ifndef AURORA_TX_SCRAMBLER_EN
    n_checks++; if (ow[15:0] !== 16'h7FFF) begin n_fail++; $display("FAIL cnt4_hdr_payload: got %h expected 7fff", ow[15:0]); end
`endif
    step(1'b1, 1'b1, 2'b01, 64'h1, or_, er, ow, ew, oi, ei);
    n_checks++; if (or_ !== 1'b0) begin n_fail++; $display("FAIL cnt50_ready: got %b expected 0", or_); end
    step(1'b1, 1'b1, 2'b01, 64'h1, or_, er, ow, ew, oi, ei);
    n_checks++; if (or_ !== 1'b0) begin n_fail++; $display("FAIL cnt30_ready: got %b expected 0", or_); end
    n_checks++; if (oi !== 1'b0) begin n_fail++; $display("FAIL held_no_idle: got %b expected 0", oi); end
    step(1'b1, 1'b1, 2'b01, 64'h1, or_, er, ow, ew, oi, ei);
    n_checks++; if (or_ !== 1'b1) begin n_fail++; $display("FAIL cnt10_ready: got %b expected 1", or_); end
  endtask

  task automatic test_lane_drop();
    logic or_, er, oi, ei;
    logic [19:0] ow, ew;
    do_reset();
    for (int k = 0; k < 20; k++)
      step(1'b1, 1'b0, 2'b01, 64'h0, or_, er, ow, ew, oi, ei);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 2'b01, 64'h55, or_, er, ow, ew, oi, ei);
      n_checks++; if (ow !== 20'h0) begin n_fail++; $display("FAIL drop_word[%0d]: got %h expected 00000", k, ow); end
      n_checks++; if (or_ !== 1'b0) begin n_fail++; $display("FAIL drop_ready[%0d]: got %b expected 0", k, or_); end
      n_checks++; if (oi !== 1'b0) begin n_fail++; $display("FAIL drop_idle[%0d]: got %b expected 0", k, oi); end
    end
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b0, 2'b01, 64'h0, or_, er, ow, ew, oi, ei);
      n_checks++;
      if (ow !== ref_idle_words[k]) begin n_fail++; $display("FAIL reenable_word[%0d]: got %h expected %h", k, ow, ref_idle_words[k]); end
    end
  endtask

  task automatic test_async_reset();
    logic or_, er, oi, ei;
    logic [19:0] ow, ew;
    do_reset();
    for (int k = 0; k < 8; k++)
      step(1'b1, 1'b1, 2'b01, {$urandom, $urandom}, or_, er, ow, ew, oi, ei);
    blk_valid = 1'b0;
    #3;
    rst_b = 1'b0;
    #1;
    n_checks++; if (ser_word !== 20'h0) begin n_fail++; $display("FAIL arst_word: got %h expected 00000", ser_word); end
    n_checks++; if (blk_ready !== 1'b0) begin n_fail++; $display("FAIL arst_ready: got %b expected 0", blk_ready); end
    n_checks++; if (idle_ins !== 1'b0) begin n_fail++; $display("FAIL arst_idle: got %b expected 0", idle_ins); end
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    model_reset();
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b0, 2'b01, 64'h0, or_, er, ow, ew, oi, ei);
      n_checks++;
      if (ow !== ref_idle_words[k]) begin n_fail++; $display("FAIL arst_recover[%0d]: got %h expected %h", k, ow, ref_idle_words[k]); end
    end
  endtask

  task automatic test_random();
    logic or_, er, oi, ei;
    logic [19:0] ow, ew;
    logic en, vld;
    logic [1:0] hdr;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      en  = ($urandom_range(0, 15) != 0);
      vld = ($urandom_range(0, 2) != 0);
      hdr = $urandom_range(0, 1) ? 2'b01 : 2'b10;
      step(en, vld, hdr, {$urandom, $urandom}, or_, er, ow, ew, oi, ei);
      n_checks++; if (or_ !== er) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", k, or_, er); end
      n_checks++; if (ow !== ew) begin n_fail++; $display("FAIL rand_word[%0d]: got %h expected %h", k, ow, ew); end
      n_checks++; if (oi !== ei) begin n_fail++; $display("FAIL rand_idle[%0d]: got %b expected %b", k, oi, ei); end
    end
  endtask

`ifdef AURORA_TX_SCRAMBLER_EN
  task automatic test_scrambler();
    logic or_, er, oi, ei;
    logic [19:0] ow, ew;
    logic [57:0] dst;
    logic [65:0] blk;
    logic [63:0] plain;
    bit rx[$];
    do_reset();
    for (int k = 0; k < 66; k++) begin
      step(1'b1, 1'b1, 2'b01, 64'h0, or_, er, ow, ew, oi, ei);
      for (int b = 19; b >= 0; b--) rx.push_back(ow[b]);
    end
    dst = '1;
    while (rx.size() >= 66) begin
      for (int b = 65; b >= 0; b--) blk[b] = rx.pop_front();
      for (int b = 63; b >= 0; b--) begin
        plain[b] = blk[b] ^ dst[38] ^ dst[57];
        dst      = {dst[56:0], blk[b]};
      end
      n_checks++; if (blk[65:64] !== 2'b01) begin n_fail++; $display("FAIL scr_hdr: got %b expected 01", blk[65:64]); end
      n_checks++; if (plain !== 64'h0) begin n_fail++; $display("FAIL scr_descramble: got %h expected 0", plain); end
    end
  endtask
`endif

  initial begin
    rst_b     = 1'b0;
    lane_en   = 1'b0;
    blk_valid = 1'b0;
    blk_hdr   = 2'b01;
    blk_data  = '0;
    test_reset();
    test_idle_stream();
    test_stream();
    test_boundary();
    test_lane_drop();
    test_async_reset();
    test_random();
`ifdef AURORA_TX_SCRAMBLER_EN
    test_scrambler();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
